wb_burst_master: RTL and testbench

- Next-generation Wishbone B4 classic master with a CPU/DMA-side request interface.
- Executes single or incrementing-burst reads and writes of 1..MAX_BURST beats under one CYC_O assertion.
- Handles ERR_I and RTY_I with bounded retry, aborts on a watchdog timeout, and returns a status code with each completion.
- Sits between the core/DMA request logic and the WB interconnect.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_burst_master_if.sv | 28 ++
 rtl/wb_watchdog.sv | 26 ++
 rtl/wb_burst_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and encodings for the Wishbone burst master.
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WDATA   = 2'd1,
      BUS     = 2'd2,
      BACKOFF = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ST_OK        = 2'b00,
      ST_BUS_ERR   = 2'b01,
      ST_RETRY_EXH = 2'b10,
      ST_TIMEOUT   = 2'b11
   } status_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   // Cycle type for a beat that is about to be strobed.
   function automatic logic [2:0] cti_for(input logic last);
      return last ? CTI_EOB : CTI_INCR;
   endfunction

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone B4 classic bus bundle between the burst master and the interconnect.
interface wb_burst_master_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0]   DAT_I;
   logic [ADDR_WIDTH-1:0]   ADR_O;
   logic [DATA_WIDTH-1:0]   DAT_O;
   logic                    WE_O;
   logic [DATA_WIDTH/8-1:0] SEL_O;
   logic                    STB_O;
   logic                    CYC_O;
   logic [2:0]              CTI_O;
   logic [1:0]              BTE_O;
   logic                    ACK_I;
   logic                    ERR_I;
   logic                    RTY_I;

   modport master (
      input  DAT_I, ACK_I, ERR_I, RTY_I,
      output ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O, CTI_O, BTE_O
   );

   modport slave (
      output DAT_I, ACK_I, ERR_I, RTY_I,
      input  ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O, CTI_O, BTE_O
   );
endinterface

// File: rtl/wb_watchdog.sv
// Loadable up-counter; o_expired_c flags the enabled cycle on which it reaches LIMIT.
module wb_watchdog #(
   parameter  int unsigned LIMIT = 255,
   localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_expired_c
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i)       r_cnt <= '0;
      else if (i_clr)  r_cnt <= '0;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_en)   r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_expired_c = i_en && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 classic burst master: request-side handshake in, retried/timed bus cycles out.
module wb_burst_master
   import wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MAX_BURST      = 8,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned BACKOFF_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic                         req_we_i,
   input  logic [ADDR_WIDTH-1:0]        req_addr_i,
   input  logic [DATA_WIDTH/8-1:0]      req_sel_i,
   input  logic [$clog2(MAX_BURST)-1:0] req_len_i,
   input  logic [DATA_WIDTH-1:0]        wdata_i,
   input  logic                         wdata_valid_i,
   output logic                         wdata_ready_o,
   output logic [DATA_WIDTH-1:0]        rdata_o,
   output logic                         rdata_valid_o,
   output logic                         done_o,
   output logic [1:0]                   status_o,
   wb_burst_master_if.master            wb
);

   localparam int unsigned LEN_W = $clog2(MAX_BURST);
   localparam int unsigned SEL_W = DATA_WIDTH / 8;
   localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

   state_t                r_state, w_ns;
   status_t               r_status, w_status;
   logic                  r_we, w_we;
   logic [LEN_W-1:0]      r_len, w_len, r_beat, w_beat;
   logic [RTY_W-1:0]      r_retry, w_retry;
   logic [ADDR_WIDTH-1:0] r_adr, w_adr;
   logic [DATA_WIDTH-1:0] r_dat, w_dat, r_rdata, w_rdata;
   logic [SEL_W-1:0]      r_sel, w_sel;
   logic [2:0]            r_cti, w_cti;
   logic                  r_stb, w_stb, r_cyc, w_cyc;
   logic                  r_req_ready, w_req_ready, r_wdata_ready, w_wdata_ready;
   logic                  r_rdata_valid, w_rdata_valid, r_done, w_done;
   logic                  w_tmo_clr, w_tmo_exp, w_bo_load, w_bo_exp;

   wb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_clr       (w_tmo_clr),
      .i_load      (1'b0),
      .i_load_val  ('0),
      .i_en        (r_state == BUS),
      .o_expired_c (w_tmo_exp)
   );

   wb_watchdog #(.LIMIT(BACKOFF_CYCLES)) u_bo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_clr       (1'b0),
      .i_load      (w_bo_load),
      .i_load_val  ('0),
      .i_en        (r_state == BACKOFF),
      .o_expired_c (w_bo_exp)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= IDLE;
         r_status      <= ST_OK;
         r_we          <= 1'b0;
         r_len         <= '0;
         r_beat        <= '0;
         r_retry       <= '0;
         r_adr         <= '0;
         r_dat         <= '0;
         r_rdata       <= '0;
         r_sel         <= '0;
         r_cti         <= CTI_CLASSIC;
         r_stb         <= 1'b0;
         r_cyc         <= 1'b0;
         r_req_ready   <= 1'b0;
         r_wdata_ready <= 1'b0;
         r_rdata_valid <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_ns;
         r_status      <= w_status;
         r_we          <= w_we;
         r_len         <= w_len;
         r_beat        <= w_beat;
         r_retry       <= w_retry;
         r_adr         <= w_adr;
         r_dat         <= w_dat;
         r_rdata       <= w_rdata;
         r_sel         <= w_sel;
         r_cti         <= w_cti;
         r_stb         <= w_stb;
         r_cyc         <= w_cyc;
         r_req_ready   <= w_req_ready;
         r_wdata_ready <= w_wdata_ready;
         r_rdata_valid <= w_rdata_valid;
         r_done        <= w_done;
      end
   end

   // Next state and next value of every registered output.
   always_comb begin
      w_ns          = r_state;
      w_status      = r_status;
      w_we          = r_we;
      w_len         = r_len;
      w_beat        = r_beat;
      w_retry       = r_retry;
      w_adr         = r_adr;
      w_dat         = r_dat;
      w_rdata       = r_rdata;
      w_sel         = r_sel;
      w_cti         = r_cti;
      w_stb         = r_stb;
      w_cyc         = r_cyc;
      w_rdata_valid = 1'b0;
      w_done        = 1'b0;
      w_tmo_clr     = 1'b0;
      w_bo_load     = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (req_valid_i && r_req_ready) begin
               w_we      = req_we_i;
               w_adr     = req_addr_i;
               w_sel     = req_sel_i;
               w_len     = req_len_i;
               w_beat    = '0;
               w_retry   = '0;
               w_tmo_clr = 1'b1;
               if (req_we_i) begin
                  w_ns  = WDATA;
                  w_stb = 1'b0;
                  w_cti = CTI_CLASSIC;
               end else begin
                  w_ns  = BUS;
                  w_cyc = 1'b1;
                  w_stb = 1'b1;
                  w_cti = cti_for(req_len_i == '0);
               end
            end
         end
         WDATA: begin
            if (wdata_valid_i && r_wdata_ready) begin
               w_dat = wdata_i;
               w_ns  = BUS;
               w_cyc = 1'b1;
               w_stb = 1'b1;
               w_cti = cti_for(r_beat == r_len);
            end
         end
         BUS: begin
            if (wb.ERR_I || wb.RTY_I) begin
               w_cyc     = 1'b0;
               w_stb     = 1'b0;
               w_cti     = CTI_CLASSIC;
               w_tmo_clr = 1'b1;
               if (wb.ERR_I) begin
                  w_done   = 1'b1;
                  w_status = ST_BUS_ERR;
                  w_ns     = IDLE;
               end else begin
                  w_retry = r_retry + RTY_W'(1);
                  if (w_retry == RTY_W'(MAX_RETRY + 1)) begin
                     w_done   = 1'b1;
                     w_status = ST_RETRY_EXH;
                     w_ns     = IDLE;
                  end else begin
                     w_bo_load = 1'b1;
                     w_ns      = BACKOFF;
                  end
               end
            end else if (wb.ACK_I) begin
               w_tmo_clr = 1'b1;
               if (!r_we) begin
                  w_rdata       = wb.DAT_I;
                  w_rdata_valid = 1'b1;
               end
               if (r_beat == r_len) begin
                  w_cyc    = 1'b0;
                  w_stb    = 1'b0;
                  w_cti    = CTI_CLASSIC;
                  w_done   = 1'b1;
                  w_status = ST_OK;
                  w_ns     = IDLE;
               end else begin
                  w_adr   = r_adr + ADDR_WIDTH'(SEL_W);
                  w_beat  = r_beat + LEN_W'(1);
                  w_retry = '0;
                  if (r_we) begin
                     w_stb = 1'b0;
                     w_cti = CTI_CLASSIC;
                     w_ns  = WDATA;
                  end else begin
                     w_cti = cti_for(w_beat == r_len);
                  end
               end
            end else if (w_tmo_exp) begin
               w_cyc    = 1'b0;
               w_stb    = 1'b0;
               w_cti    = CTI_CLASSIC;
               w_done   = 1'b1;
               w_status = ST_TIMEOUT;
               w_ns     = IDLE;
            end
         end
         BACKOFF: begin
            // Reissue the same beat; address, data and sel were never touched.
            if (w_bo_exp) begin
               w_ns  = BUS;
               w_cyc = 1'b1;
               w_stb = 1'b1;
               w_cti = cti_for(r_beat == r_len);
            end
         end
         default: w_ns = IDLE;
      endcase

      w_req_ready   = (w_ns == IDLE);
      w_wdata_ready = (w_ns == WDATA);
   end

   assign req_ready_o   = r_req_ready;
   assign wdata_ready_o = r_wdata_ready;
   assign rdata_o       = r_rdata;
   assign rdata_valid_o = r_rdata_valid;
   assign done_o        = r_done;
   assign status_o      = r_status;
   assign wb.ADR_O      = r_adr;
   assign wb.DAT_O      = r_dat;
   assign wb.WE_O       = r_we;
   assign wb.SEL_O      = r_sel;
   assign wb.STB_O      = r_stb;
   assign wb.CYC_O      = r_cyc;
   assign wb.CTI_O      = r_cti;
   assign wb.BTE_O      = BTE_LINEAR;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master with a scripted Wishbone slave model.
module tb_wb_burst_master;

   localparam int unsigned PERIOD = 10;
   localparam int R_NONE = 0, R_ACK = 1, R_ERR = 2, R_RTY = 3, R_ERRACK = 4;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
      logic [3:0]  sel;
      logic [2:0]  cti;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_we_i, wdata_valid_i;
   logic [31:0] req_addr_i, wdata_i;
   logic [3:0]  req_sel_i;
   logic [2:0]  req_len_i;
   logic        req_ready_o, wdata_ready_o, rdata_valid_o, done_o;
   logic [31:0] rdata_o;
   logic [1:0]  status_o;

   wb_burst_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb_bus ();

   wb_burst_master dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_addr_i    (req_addr_i),
      .req_sel_i     (req_sel_i),
      .req_len_i     (req_len_i),
      .wdata_i       (wdata_i),
      .wdata_valid_i (wdata_valid_i),
      .wdata_ready_o (wdata_ready_o),
      .rdata_o       (rdata_o),
      .rdata_valid_o (rdata_valid_o),
      .done_o        (done_o),
      .status_o      (status_o),
      .wb            (wb_bus)
   );

   always #(PERIOD / 2) clk = ~clk;

   int unsigned n_chk = 0, n_fail = 0;
   int unsigned n_stb = 0, n_cyc = 0, n_cyc_fall = 0, n_rv = 0, n_done = 0, n_wd_hi = 0;
   int unsigned gap = 0;
   int unsigned gaps[$];
   logic [31:0] exp_rd[$];
   int          exp_st[$];
   beat_t       exp_beat[$];
   int          resp_q[$];
   logic [31:0] wd_q[$];
   int          wd_stall[$];
   time         acc_t, rv_t, done_t;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] f_mem(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
   endfunction

   // Slave model and output monitor, all sampled on the falling edge.
   initial begin
      int    r;
      logic  prev_cyc, err_prev;
      beat_t b;
      prev_cyc = 1'b0; err_prev = 1'b0;
      wb_bus.ACK_I = 1'b0; wb_bus.ERR_I = 1'b0; wb_bus.RTY_I = 1'b0; wb_bus.DAT_I = '0;
      wdata_valid_i = 1'b0; wdata_i = '0;
      forever begin
         @(negedge clk);
         if (rdata_valid_o) begin
            n_rv++; rv_t = $time;
            if (exp_rd.size() == 0) chk("rdata_unexpected", 64'(rdata_o), 64'hX);
            else chk("rdata", 64'(rdata_o), 64'(exp_rd.pop_front()));
         end
         if (done_o) begin
            n_done++; done_t = $time;
            if (exp_st.size() == 0) chk("done_unexpected", 64'(status_o), 64'hX);
            else chk("status", 64'(status_o), 64'(exp_st.pop_front()));
         end
         if (err_prev) chk("err_cyc_drop", 64'(wb_bus.CYC_O), 64'd0);
         err_prev = 1'b0;
         if (wb_bus.CYC_O) begin
            n_cyc++;
            if (!prev_cyc && gap > 0) gaps.push_back(gap);
            gap = 0;
         end else if (!req_ready_o) gap++;
         else gap = 0;
         if (prev_cyc && !wb_bus.CYC_O) n_cyc_fall++;
         prev_cyc = wb_bus.CYC_O;

         wb_bus.ACK_I = 1'b0; wb_bus.ERR_I = 1'b0; wb_bus.RTY_I = 1'b0;
         wb_bus.DAT_I = f_mem(wb_bus.ADR_O);
         r = R_NONE;
         if (wb_bus.CYC_O && wb_bus.STB_O) begin
            n_stb++;
            if (resp_q.size() > 0) r = resp_q.pop_front();
         end
         if (r != R_NONE) begin
            if (exp_beat.size() == 0) chk("beat_unexpected", 64'(wb_bus.ADR_O), 64'hX);
            else begin
               b = exp_beat[0];
               chk("adr", 64'(wb_bus.ADR_O), 64'(b.adr));
               chk("cti", 64'(wb_bus.CTI_O), 64'(b.cti));
               chk("we",  64'(wb_bus.WE_O),  64'(b.we));
               chk("sel", 64'(wb_bus.SEL_O), 64'(b.sel));
               if (b.we) chk("dat_o", 64'(wb_bus.DAT_O), 64'(b.dat));
            end
            wb_bus.ACK_I = (r == R_ACK) || (r == R_ERRACK);
            wb_bus.ERR_I = (r == R_ERR) || (r == R_ERRACK);
            wb_bus.RTY_I = (r == R_RTY);
            if (r == R_ACK && exp_beat.size() > 0) void'(exp_beat.pop_front());
            err_prev = wb_bus.ERR_I;
         end

         wdata_valid_i = 1'b0;
         if (wdata_ready_o) begin
            if (wb_bus.CYC_O) n_wd_hi++;
            if (wd_stall.size() > 0) begin
               if (wd_stall[0] > 0) wd_stall[0] = wd_stall[0] - 1;
               else begin
                  wdata_valid_i = 1'b1;
                  wdata_i = wd_q.pop_front();
                  void'(wd_stall.pop_front());
               end
            end
         end
      end
   end

   task automatic push_beat(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                            input logic [3:0] sel, input logic [2:0] cti);
      beat_t b;
      b.adr = adr; b.dat = dat; b.we = we; b.sel = sel; b.cti = cti;
      exp_beat.push_back(b);
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [2:0] len);
      int k;
      k = 0;
      @(negedge clk);
      while (!req_ready_o && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) chk("req_ready_timeout", 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_sel_i = sel; req_len_i = len;
      acc_t = $time;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int unsigned d0;
      int k;
      d0 = n_done; k = 0;
      while (n_done == d0 && k < budget) begin @(posedge clk); #1; k++; end
      if (n_done == d0) chk("done_timeout", 64'd0, 64'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned s0, c0, f0, r0, w0, g0, d0;
      rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
      req_addr_i = '0; req_sel_i = '0; req_len_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'(|{req_ready_o, wdata_ready_o, rdata_o, rdata_valid_o, done_o,
          status_o, wb_bus.ADR_O, wb_bus.DAT_O, wb_bus.WE_O, wb_bus.SEL_O, wb_bus.STB_O,
          wb_bus.CYC_O, wb_bus.CTI_O, wb_bus.BTE_O}), 64'd0);
      @(posedge clk); #1 rst_i = 1'b0;

      // Single read with immediate ACK
      c0 = n_cyc;
      push_beat(32'h100, 32'h0, 1'b0, 4'hF, 3'b111);
      exp_rd.push_back(32'hDEAD_BEEF); exp_st.push_back(0); resp_q.push_back(R_ACK);
      do_req(1'b0, 32'h100, 4'hF, 3'd0);
      wait_done(100);
      chk("t1_rv_latency", 64'(rv_t - acc_t), 64'(2 * PERIOD));
      chk("t1_done_latency", 64'(done_t - acc_t), 64'(2 * PERIOD));
      chk("t1_cyc_cycles", 64'(n_cyc - c0), 64'd1);

      // Four-beat incrementing read
      c0 = n_cyc; f0 = n_cyc_fall; r0 = n_rv; d0 = n_done;
      for (int i = 0; i < 4; i++) begin
         push_beat(32'h1000 + 32'(4 * i), 32'h0, 1'b0, 4'h3, (i < 3) ? 3'b010 : 3'b111);
         exp_rd.push_back(f_mem(32'h1000 + 32'(4 * i)));
         resp_q.push_back(R_ACK);
      end
      exp_st.push_back(0);
      do_req(1'b0, 32'h1000, 4'h3, 3'd3);
      wait_done(100);
      chk("t2_cyc_cycles", 64'(n_cyc - c0), 64'd4);
      chk("t2_cyc_falls", 64'(n_cyc_fall - f0), 64'd1);
      chk("t2_rv_pulses", 64'(n_rv - r0), 64'd4);
      chk("t2_done_pulses", 64'(n_done - d0), 64'd1);
      chk("t2_beats_left", 64'(exp_beat.size()), 64'd0);

      // Three-beat write, data stalled five cycles before the second beat
      s0 = n_stb; w0 = n_wd_hi;
      for (int i = 0; i < 3; i++) begin
         push_beat(32'h2000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 1'b1, 4'hC,
                   (i < 2) ? 3'b010 : 3'b111);
         wd_q.push_back(32'h1111_1111 * 32'(i + 1));
         wd_stall.push_back((i == 1) ? 5 : 0);
         resp_q.push_back(R_ACK);
      end
      exp_st.push_back(0);
      do_req(1'b1, 32'h2000, 4'hC, 3'd2);
      wait_done(100);
      chk("t3_stb_cycles", 64'(n_stb - s0), 64'd3);
      chk("t3_wdata_wait_cyc_high", 64'(n_wd_hi - w0), 64'd7);
      chk("t3_beats_left", 64'(exp_beat.size()), 64'd0);

      // Write retried twice, then acknowledged
      s0 = n_stb; f0 = n_cyc_fall; g0 = gaps.size();
      push_beat(32'h3000, 32'hCAFE_F00D, 1'b1, 4'hF, 3'b111);
      wd_q.push_back(32'hCAFE_F00D); wd_stall.push_back(0);
      resp_q.push_back(R_RTY); resp_q.push_back(R_RTY); resp_q.push_back(R_ACK);
      exp_st.push_back(0);
      do_req(1'b1, 32'h3000, 4'hF, 3'd0);
      wait_done(100);
      chk("t4_stb_cycles", 64'(n_stb - s0), 64'd3);
      chk("t4_cyc_falls", 64'(n_cyc_fall - f0), 64'd3);
      chk("t4_gap_count", 64'(gaps.size() - g0), 64'd3);
      for (int i = int'(g0); i < gaps.size(); i++)
         chk("t4_gap_len", 64'(gaps[i]), (i == int'(g0)) ? 64'd1 : 64'd4);

      // Retries exhausted
      s0 = n_stb;
      push_beat(32'h3100, 32'h0, 1'b0, 4'hF, 3'b111);
      for (int i = 0; i < 4; i++) resp_q.push_back(R_RTY);
      exp_st.push_back(2);
      do_req(1'b0, 32'h3100, 4'hF, 3'd0);
      wait_done(100);
      repeat (10) @(posedge clk);
      #1;
      chk("t4b_stb_cycles", 64'(n_stb - s0), 64'd4);
      exp_beat.delete();

      // ERR together with ACK on beat 1 of 4
      r0 = n_rv;
      push_beat(32'h4000, 32'h0, 1'b0, 4'hF, 3'b010);
      push_beat(32'h4004, 32'h0, 1'b0, 4'hF, 3'b010);
      exp_rd.push_back(f_mem(32'h4000));
      resp_q.push_back(R_ACK); resp_q.push_back(R_ERRACK);
      exp_st.push_back(1);
      do_req(1'b0, 32'h4000, 4'hF, 3'd3);
      wait_done(100);
      chk("t5_rv_pulses", 64'(n_rv - r0), 64'd1);
      exp_beat.delete();

      // Silent slave
      s0 = n_stb;
      exp_st.push_back(3);
      do_req(1'b0, 32'h5000, 4'hF, 3'd0);
      wait_done(400);
      chk("t6_stb_cycles", 64'(n_stb - s0), 64'd255);

      // Reset in the middle of a burst
      push_beat(32'h6000, 32'h0, 1'b0, 4'hF, 3'b010);
      exp_rd.push_back(f_mem(32'h6000));
      resp_q.push_back(R_ACK);
      do_req(1'b0, 32'h6000, 4'hF, 3'd3);
      repeat (3) @(posedge clk);
      #1;
      d0 = n_done;
      rst_i = 1'b1; resp_q.delete();
      @(posedge clk); #1 rst_i = 1'b0;
      @(negedge clk);
      chk("t7_outputs_after_reset", 64'(|{req_ready_o, wdata_ready_o, rdata_o, rdata_valid_o,
          done_o, status_o, wb_bus.ADR_O, wb_bus.DAT_O, wb_bus.WE_O, wb_bus.SEL_O,
          wb_bus.STB_O, wb_bus.CYC_O, wb_bus.CTI_O, wb_bus.BTE_O}), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("t7_no_done", 64'(n_done - d0), 64'd0);
      chk("t7_rd_left", 64'(exp_rd.size()), 64'd0);
      exp_beat.delete();

      // Normal request after reset
      push_beat(32'h104, 32'h0, 1'b0, 4'h1, 3'b111);
      exp_rd.push_back(f_mem(32'h104)); exp_st.push_back(0); resp_q.push_back(R_ACK);
      do_req(1'b0, 32'h104, 4'h1, 3'd0);
      wait_done(100);
      chk("t8_rd_left", 64'(exp_rd.size()), 64'd0);
      chk("t8_st_left", 64'(exp_st.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
